// File: rtl/ov7670_stream_tx.sv
// ============================================================================
// Module   : ov7670_stream_tx
// Purpose  : OV7670-style parallel camera emulator (PCLK/VS/HREF/D) that
//            streams RGB565 test patterns in place of a physical sensor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ov7670_stream_tx #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 144,
    parameter int VS_LINES = 3,
    parameter int V_BACK   = 17,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] mode,
    output logic       pclk,
    output logic       vs,
    output logic       href,
    output logic [7:0] d,
    output logic       frame_done,
    output logic [7:0] frame_cnt
);

    localparam int LINE   = 2 * H_ACTIVE + H_BLANK;
    localparam int CC_W   = $clog2(LINE);
    localparam int M_A    = (VS_LINES > V_BACK) ? VS_LINES : V_BACK;
    localparam int M_B    = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int LC_MAX = (M_A > M_B) ? M_A : M_B;
    localparam int LC_W   = (LC_MAX > 1) ? $clog2(LC_MAX) : 1;

    localparam logic [CC_W-1:0] CC_LAST  = CC_W'(LINE - 1);
    localparam logic [CC_W:0]   HREF_END = (CC_W + 1)'(2 * H_ACTIVE);
    localparam logic [LC_W-1:0] VS_LAST  = LC_W'(VS_LINES - 1);
    localparam logic [LC_W-1:0] VB_LAST  = LC_W'(V_BACK - 1);
    localparam logic [LC_W-1:0] VA_LAST  = LC_W'(V_ACTIVE - 1);
    localparam logic [LC_W-1:0] VF_LAST  = LC_W'(V_FRONT - 1);
    localparam logic [15:0]     BAR_W    = 16'(H_ACTIVE / 8);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VSYNC  = 3'd1;
    localparam logic [2:0] S_VBACK  = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_VFRONT = 3'd4;

    logic [2:0]      state, state_n;
    logic            ph;
    logic [CC_W-1:0] cc, cc_n;
    logic [LC_W-1:0] lc, lc_n, lc_last;
    logic            start, done;
    logic [1:0]      mode_l;
    logic [7:0]      fc_l;
    logic [15:0]     x;
    logic [7:0]      y;
    logic [2:0]      bar;
    logic [15:0]     pix;
    logic            href_n;
    logic [7:0]      d_n;

    assign pclk = ph;

    // Everything except the phase bit advances only on ticks (pclk falling).
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else if (ph) begin
            state <= state_n;
        end
    end

    always_comb begin
        case (state)
            S_VSYNC:  lc_last = VS_LAST;
            S_VBACK:  lc_last = VB_LAST;
            S_ACTIVE: lc_last = VA_LAST;
            default:  lc_last = VF_LAST;
        endcase
    end

    always_comb begin
        state_n = state;
        cc_n    = cc;
        lc_n    = lc;
        start   = 1'b0;
        done    = 1'b0;
        if (state == S_IDLE) begin
            if (enable) begin
                state_n = S_VSYNC;
                cc_n    = '0;
                lc_n    = '0;
                start   = 1'b1;
            end
        end else if (cc != CC_LAST) begin
            cc_n = cc + CC_W'(1);
        end else begin
            cc_n = '0;
            if (lc != lc_last) begin
                lc_n = lc + LC_W'(1);
            end else begin
                lc_n = '0;
                case (state)
                    S_VSYNC:  state_n = S_VBACK;
                    S_VBACK:  state_n = S_ACTIVE;
                    S_ACTIVE: state_n = S_VFRONT;
                    default: begin
                        done = 1'b1;
                        if (enable) begin
                            state_n = S_VSYNC;
                            start   = 1'b1;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    // Byte for the position being entered; registered on the same tick.
    always_comb begin
        x   = 16'(cc_n >> 1);
        y   = 8'(lc_n);
        bar = 3'(x / BAR_W);
        pix = 16'h0000;
        case (mode_l)
            2'd0: begin
                case (bar)
                    3'd0:    pix = 16'hFFFF;
                    3'd1:    pix = 16'hFFE0;
                    3'd2:    pix = 16'h07FF;
                    3'd3:    pix = 16'h07E0;
                    3'd4:    pix = 16'hF81F;
                    3'd5:    pix = 16'hF800;
                    3'd6:    pix = 16'h001F;
                    default: pix = 16'h0000;
                endcase
            end
            2'd1:    pix = {x[4:0], x[5:0], x[4:0]};
            2'd2:    pix = (x[3] ^ y[3]) ? 16'hFFFF : 16'h0000;
            default: pix = {fc_l, y};
        endcase
        href_n = (state_n == S_ACTIVE) && ({1'b0, cc_n} < HREF_END);
        d_n    = href_n ? (cc_n[0] ? pix[7:0] : pix[15:8]) : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ph         <= 1'b0;
            cc         <= '0;
            lc         <= '0;
            vs         <= 1'b0;
            href       <= 1'b0;
            d          <= 8'h00;
            frame_done <= 1'b0;
            frame_cnt  <= 8'h00;
            mode_l     <= 2'd0;
            fc_l       <= 8'h00;
        end else begin
            ph         <= ~ph;
            frame_done <= 1'b0;
            if (ph) begin
                cc   <= cc_n;
                lc   <= lc_n;
                vs   <= (state_n == S_VSYNC);
                href <= href_n;
                d    <= d_n;
                if (done) begin
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + 8'd1;
                end
                // Back-to-back frames must see the count that includes the frame just ended.
                if (start) begin
                    mode_l <= mode;
                    fc_l   <= done ? (frame_cnt + 8'd1) : frame_cnt;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ov7670_stream_tx.sv
// ============================================================================
// Module   : tb_ov7670_stream_tx
// Purpose  : Self-checking bench for ov7670_stream_tx with a byte scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ov7670_stream_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       pclk, vs, href, frame_done;
    logic [7:0] d, frame_cnt;

    ov7670_stream_tx #(
        .H_ACTIVE(8), .H_BLANK(4), .VS_LINES(1),
        .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode),
        .pclk(pclk), .vs(vs), .href(href), .d(d),
        .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   mode;
        logic [127:0] line;
        int           fcnt;
    } vec_t;

    vec_t       tbl [3];
    logic [7:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int vs_rise_t = 0, vs_fall_t = 0, href_rise_t = 0, href_fall_t = 0;
    int href_first_t = -1, href_pulses = 0, vs_rises = 0, fd_cnt = 0, fd_t = 0;
    int width_err = 0, gap_err = 0;
    logic pclk_q = 1'b0, vs_q = 1'b0, href_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Timing recorder and scoreboard consumer: one byte per pclk rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (!vs_q && vs) begin
                vs_rise_t = cyc; vs_rises++; href_pulses = 0; href_first_t = -1;
            end
            if (vs_q && !vs) vs_fall_t = cyc;
            if (!href_q && href) begin
                if (href_pulses > 0 && (cyc - href_fall_t) != 8) gap_err++;
                if (href_first_t < 0) href_first_t = cyc;
                href_rise_t = cyc;
            end
            if (href_q && !href) begin
                href_pulses++; href_fall_t = cyc;
                if ((cyc - href_rise_t) != 32) width_err++;
            end
            if (frame_done) begin fd_cnt++; fd_t = cyc; end
            if (pclk && !pclk_q && href) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL byte: got %02h with no byte expected", d);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (d !== e) begin
                        errors++;
                        $display("FAIL byte: got %02h want %02h", d, e);
                    end
                end
            end
        end
        pclk_q = pclk; vs_q = vs; href_q = href;
    end

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic push_frame(input logic [127:0] ln);
        for (int y = 0; y < 4; y++)
            for (int b = 0; b < 16; b++)
                exp_q.push_back(ln[127-8*b -: 8]);
    endtask

    task automatic wait_vs_rise(input int bound, output bit ok);
        int s = vs_rises;
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            step();
            if (vs_rises != s) ok = 1'b1;
        end
    endtask

    task automatic wait_fd(input int bound, output bit ok);
        int s = fd_cnt;
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            step();
            if (fd_cnt != s) ok = 1'b1;
        end
    endtask

    task automatic wait_href(input int want_pulses, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            step();
            if (href && href_pulses == want_pulses) ok = 1'b1;
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int s_vs, s_fd, tog_err, sync_err, prev_fd;
        logic p;

        tbl[0] = '{2'd0, 128'hFFFF_FFE0_07FF_07E0_F81F_F800_001F_0000, 1};
        tbl[1] = '{2'd1, 128'h0000_0821_1042_1863_2084_28A5_30C6_38E7, 2};
        tbl[2] = '{2'd2, 128'h0000_0000_0000_0000_0000_0000_0000_0000, 3};

        // Reset and idle behaviour
        repeat (3) step();
        chk("reset_pclk", int'(pclk), 0);
        chk("reset_sync", int'({vs, href, frame_done}), 0);
        chk("reset_d", int'(d), 0);
        chk("reset_frame_cnt", int'(frame_cnt), 0);
        rst = 1'b0;
        tog_err = 0; sync_err = 0; p = pclk;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (pclk === p) tog_err++;
            p = pclk;
            if (vs || href || d != 8'h00) sync_err++;
        end
        chk("idle_pclk_toggle", tog_err, 0);
        chk("idle_outputs_quiet", sync_err, 0);

        // Table-driven single frames, one per pattern
        for (int i = 0; i < 3; i++) begin
            push_frame(tbl[i].line);
            mode = tbl[i].mode;
            enable = 1'b1;
            s_fd = fd_cnt;
            wait_vs_rise(20, ok);
            chk("vs_start", int'(ok), 1);
            enable = 1'b0;
            wait_fd(400, ok);
            chk("frame_done_seen", int'(ok), 1);
            chk("frame_cnt", int'(frame_cnt), tbl[i].fcnt);
            if (i == 0) begin
                chk("vs_width", vs_fall_t - vs_rise_t, 40);
                chk("vs_to_href", href_first_t - vs_rise_t, 80);
                chk("vs_to_done", fd_t - vs_rise_t, 280);
            end
            s_vs = vs_rises;
            repeat (20) step();
            chk("frame_done_width", fd_cnt - s_fd, 1);
            chk("href_pulses", href_pulses, 4);
            chk("queue_drained", exp_q.size(), 0);
            chk("stays_idle", vs_rises - s_vs, 0);
        end
        chk("href_width_errs", width_err, 0);
        chk("href_gap_errs", gap_err, 0);

        // Enable dropped during ACTIVE line 2: frame still completes
        push_frame(tbl[1].line);
        mode = 2'd1;
        enable = 1'b1;
        wait_vs_rise(20, ok);
        chk("stop_vs_start", int'(ok), 1);
        wait_href(2, 300, ok);
        chk("stop_line2_reached", int'(ok), 1);
        enable = 1'b0;
        s_fd = fd_cnt;
        wait_fd(400, ok);
        chk("stop_frame_done", int'(ok), 1);
        chk("stop_frame_cnt", int'(frame_cnt), 4);
        s_vs = vs_rises;
        repeat (300) step();
        chk("stop_href_pulses", href_pulses, 4);
        chk("stop_no_new_frame", vs_rises - s_vs, 0);
        chk("stop_single_done", fd_cnt - s_fd, 1);
        chk("stop_queue_drained", exp_q.size(), 0);

        // Back-to-back mode 3 frames through the 8-bit wrap
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        exp_q.delete();
        chk("b2b_reset_cnt", int'(frame_cnt), 0);
        for (int n = 0; n < 256; n++)
            for (int y = 0; y < 4; y++)
                for (int x = 0; x < 8; x++) begin
                    exp_q.push_back(8'(n));
                    exp_q.push_back(8'(y));
                end
        mode = 2'd3;
        enable = 1'b1;
        prev_fd = -1;
        for (int n = 0; n < 256; n++) begin
            wait_fd(400, ok);
            chk("b2b_frame_done", int'(ok), 1);
            if (!ok) break;
            chk("b2b_frame_cnt", int'(frame_cnt), (n + 1) % 256);
            if (n < 255) chk("b2b_no_gap", int'(vs), 1);
            if (prev_fd >= 0) chk("b2b_period", fd_t - prev_fd, 280);
            prev_fd = fd_t;
            if (n == 254) enable = 1'b0;
        end
        repeat (10) step();
        chk("wrap_frame_cnt", int'(frame_cnt), 0);
        chk("b2b_ends_idle", int'(vs), 0);
        chk("b2b_queue_drained", exp_q.size(), 0);

        // Reset while href is high, then a full restart
        push_frame(tbl[0].line);
        mode = 2'd0;
        enable = 1'b1;
        wait_href(0, 300, ok);
        chk("rst_mid_href_seen", int'(ok), 1);
        rst = 1'b1;
        step();
        chk("rst_mid_href", int'(href), 0);
        chk("rst_mid_d", int'(d), 0);
        chk("rst_mid_vs", int'(vs), 0);
        chk("rst_mid_pclk", int'(pclk), 0);
        step();
        exp_q.delete();
        push_frame(tbl[0].line);
        rst = 1'b0;
        wait_vs_rise(4, ok);
        chk("restart_vs", int'(ok), 1);
        enable = 1'b0;
        wait_fd(400, ok);
        chk("restart_done", int'(ok), 1);
        chk("restart_vs_to_href", href_first_t - vs_rise_t, 80);
        chk("restart_frame_cnt", int'(frame_cnt), 1);
        repeat (20) step();
        chk("restart_href_pulses", href_pulses, 4);
        chk("restart_queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
